// File: rtl/mips_core_pkg.sv
// Shared types for the MIPS core: ALU operation encoding, ROB tag width
// and the result entry that travels to the common data bus.
package mips_core_pkg;

  localparam int ROB_TAG_BITS = 6;

  typedef logic [ROB_TAG_BITS-1:0] rob_tag_t;

  // Encodings 13..15 are unused and yield a zero result.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11,
    ALU_MUL  = 4'd12
  } alu_ctl_t;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } mul_state_t;

  typedef struct packed {
    rob_tag_t    tag;
    logic [31:0] data;
  } result_entry_t;

endpackage

// File: rtl/alu_execute_unit_if.sv
// Issue port from the ALU reservation station plus the CDB request/grant port.
interface alu_execute_unit_if;
  import mips_core_pkg::*;

  logic        in_valid;
  alu_ctl_t    in_alu_ctl;
  rob_tag_t    in_tag;
  logic [31:0] in_op1;
  logic [31:0] in_op2;
  logic        stall;
  logic        cdb_req;
  rob_tag_t    cdb_tag;
  logic [31:0] cdb_data;
  logic        cdb_grant;

  modport master (
    output in_valid, in_alu_ctl, in_tag, in_op1, in_op2, cdb_grant,
    input  stall, cdb_req, cdb_tag, cdb_data
  );

  modport slave (
    input  in_valid, in_alu_ctl, in_tag, in_op1, in_op2, cdb_grant,
    output stall, cdb_req, cdb_tag, cdb_data
  );

endinterface

// File: rtl/alu_execute_unit_datapath.sv
// Single-cycle ALU operations; multiply is handled by the FSM in the top.
module alu_datapath
  import mips_core_pkg::*;
(
  input  alu_ctl_t    alu_ctl,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (alu_ctl)
      ALU_ADD:  result = op1 + op2;
      ALU_SUB:  result = op1 - op2;
      ALU_AND:  result = op1 & op2;
      ALU_OR:   result = op1 | op2;
      ALU_XOR:  result = op1 ^ op2;
      ALU_NOR:  result = ~(op1 | op2);
      ALU_SLT:  result = {31'd0, $signed(op1) < $signed(op2)};
      ALU_SLTU: result = {31'd0, op1 < op2};
      ALU_SLL:  result = op1 << op2[4:0];
      ALU_SRL:  result = op1 >> op2[4:0];
      ALU_SRA:  result = $unsigned($signed(op1) >>> op2[4:0]);
      ALU_LUI:  result = {op2[15:0], 16'd0};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_execute_unit.sv
// ALU execute unit: single-cycle ops plus a multi-cycle multiply, feeding a
// small in-order result buffer that requests the common data bus.
module alu_execute_unit
  import mips_core_pkg::*;
#(
  parameter int MUL_LATENCY   = 4,
  parameter int OUT_BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  alu_execute_unit_if.slave   bus
);

  localparam int PTR_BITS = $clog2(OUT_BUF_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam logic [3:0]          MUL_LOAD   = 4'(MUL_LATENCY - 1);
  localparam logic [CNT_BITS-1:0] FULL_COUNT = CNT_BITS'(OUT_BUF_DEPTH);

  mul_state_t           state_reg, state_next;
  logic [3:0]           mul_cnt_reg;
  logic [31:0]          mul_op1_reg, mul_op2_reg;
  rob_tag_t             mul_tag_reg;
  logic [CNT_BITS-1:0]  fill_reg;
  logic [PTR_BITS-1:0]  wr_ptr_reg, rd_ptr_reg;
  result_entry_t        buf_mem [OUT_BUF_DEPTH];

  logic          stall, mul_done;
  logic          accept, issue_mul, push_alu, push_mul, push, pop;
  logic [31:0]   alu_result, mul_result;
  result_entry_t push_entry, head_entry;

  alu_datapath u_datapath (
    .alu_ctl (bus.in_alu_ctl),
    .op1     (bus.in_op1),
    .op2     (bus.in_op2),
    .result  (alu_result)
  );

  assign mul_result = mul_op1_reg * mul_op2_reg;

  // Stall depends only on registered state, never on this cycle's inputs.
  always_comb begin
    stall    = (state_reg == ST_MUL_BUSY) || (fill_reg == FULL_COUNT);
    mul_done = (state_reg == ST_MUL_BUSY) && (mul_cnt_reg == 4'd0);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (issue_mul) state_next = ST_MUL_BUSY;
      ST_MUL_BUSY: if (mul_done)  state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  assign accept    = bus.in_valid && !stall && !flush;
  assign issue_mul = accept && (bus.in_alu_ctl == ALU_MUL);
  assign push_alu  = accept && !issue_mul;
  assign push_mul  = mul_done && !flush;
  assign push      = push_alu || push_mul;
  assign pop       = (fill_reg != '0) && bus.cdb_grant && !flush;

  // A multiply completion cannot coincide with an issue: stall is high while busy.
  always_comb begin
    push_entry.tag  = bus.in_tag;
    push_entry.data = alu_result;
    if (push_mul) begin
      push_entry.tag  = mul_tag_reg;
      push_entry.data = mul_result;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush)                                  mul_cnt_reg <= 4'd0;
    else if (issue_mul)                                   mul_cnt_reg <= MUL_LOAD;
    else if (state_reg == ST_MUL_BUSY && mul_cnt_reg != 0) mul_cnt_reg <= mul_cnt_reg - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (issue_mul) begin
      mul_op1_reg <= bus.in_op1;
      mul_op2_reg <= bus.in_op2;
      mul_tag_reg <= bus.in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_mem[wr_ptr_reg] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   fill_reg <= fill_reg + 1'b1;
        2'b01:   fill_reg <= fill_reg - 1'b1;
        default: fill_reg <= fill_reg;
      endcase
    end
  end

  // Mask the head so an empty buffer presents zeros regardless of RAM contents.
  assign head_entry   = buf_mem[rd_ptr_reg];
  assign bus.stall    = stall;
  assign bus.cdb_req  = (fill_reg != '0);
  assign bus.cdb_tag  = bus.cdb_req ? head_entry.tag  : '0;
  assign bus.cdb_data = bus.cdb_req ? head_entry.data : '0;

endmodule

// File: tb/tb_alu_execute_unit.sv
// Directed bench for alu_execute_unit: single-cycle ops, multiply latency,
// buffer back-pressure, flush and reset behaviour.
module tb_alu_execute_unit;
  import mips_core_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_checks;
  int   n_fail;

  alu_execute_unit_if bus();

  alu_execute_unit #(.MUL_LATENCY(4), .OUT_BUF_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input alu_ctl_t ctl, input logic [5:0] tag,
                             input logic [31:0] a, input logic [31:0] b);
    bus.in_valid   = 1'b1;
    bus.in_alu_ctl = ctl;
    bus.in_tag     = tag;
    bus.in_op1     = a;
    bus.in_op2     = b;
    $display("issue ctl=%0d tag=%0d op1=0x%08h op2=0x%08h", ctl, tag, a, b);
  endtask

  task automatic run_op(input string name, input alu_ctl_t ctl, input logic [5:0] tag,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    drive_issue(ctl, tag, a, b);
    step();
    bus.in_valid = 1'b0;
    check_eq({name, "_req"},  32'(bus.cdb_req), 32'd1);
    check_eq({name, "_tag"},  32'(bus.cdb_tag), 32'(tag));
    check_eq({name, "_data"}, bus.cdb_data, exp);
    step();
    check_eq({name, "_empty"}, 32'(bus.cdb_req), 32'd0);
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    flush          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_alu_ctl = ALU_ADD;
    bus.in_tag     = '0;
    bus.in_op1     = '0;
    bus.in_op2     = '0;
    bus.cdb_grant  = 1'b0;
    step();
    step();
    check_eq("rst_stall", 32'(bus.stall),   32'd0);
    check_eq("rst_req",   32'(bus.cdb_req), 32'd0);
    check_eq("rst_tag",   32'(bus.cdb_tag), 32'd0);
    check_eq("rst_data",  bus.cdb_data,     32'd0);

    // ADD 7+5 tag 3, grant held high.
    rst_n         = 1'b1;
    bus.cdb_grant = 1'b1;
    run_op("add", ALU_ADD, 6'd3, 32'd7, 32'd5, 32'd12);

    run_op("slt",   ALU_SLT,  6'd4,  32'hFFFF_FFFF, 32'd1,          32'd1);
    run_op("sltu",  ALU_SLTU, 6'd5,  32'hFFFF_FFFF, 32'd1,          32'd0);
    run_op("sra",   ALU_SRA,  6'd6,  32'h8000_0000, 32'd4,          32'hF800_0000);
    run_op("srl",   ALU_SRL,  6'd7,  32'h8000_0000, 32'd4,          32'h0800_0000);
    run_op("sub",   ALU_SUB,  6'd8,  32'd5,         32'd7,          32'hFFFF_FFFE);
    run_op("nor",   ALU_NOR,  6'd13, 32'h0F0F_0000, 32'h0000_00F0,  32'hF0F0_FF0F);
    run_op("sll",   ALU_SLL,  6'd14, 32'd1,         32'd33,         32'd2);
    run_op("lui",   ALU_LUI,  6'd15, 32'hDEAD_BEEF, 32'hFFFF_1234,  32'h1234_0000);
    run_op("xor",   ALU_XOR,  6'd16, 32'hFF00_FF00, 32'h0FF0_0FF0,  32'hF0F0_F0F0);
    run_op("unsup", alu_ctl_t'(4'hF), 6'd17, 32'd7, 32'd5,         32'd0);

    // MUL 0x10000 x 0x10001 tag 9: four busy cycles, then the result.
    drive_issue(ALU_MUL, 6'd9, 32'h0001_0000, 32'h0001_0001);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("mul_stall_busy", 32'(bus.stall),   32'd1);
      check_eq("mul_req_busy",   32'(bus.cdb_req), 32'd0);
      step();
    end
    check_eq("mul_stall_done", 32'(bus.stall),   32'd0);
    check_eq("mul_req",        32'(bus.cdb_req), 32'd1);
    check_eq("mul_tag",        32'(bus.cdb_tag), 32'd9);
    check_eq("mul_data",       bus.cdb_data,     32'h0001_0000);
    step();
    check_eq("mul_popped", 32'(bus.cdb_req), 32'd0);

    // Back-pressure: grant low, three back-to-back issues.
    bus.cdb_grant = 1'b0;
    drive_issue(ALU_ADD, 6'd10, 32'd1, 32'd1);
    step();
    check_eq("bp_stall_1", 32'(bus.stall), 32'd0);
    drive_issue(ALU_ADD, 6'd11, 32'd2, 32'd2);
    step();
    check_eq("bp_stall_2", 32'(bus.stall), 32'd1);
    drive_issue(ALU_ADD, 6'd12, 32'd3, 32'd3);
    step();
    check_eq("bp_stall_held", 32'(bus.stall),   32'd1);
    check_eq("bp_head_a_tag", 32'(bus.cdb_tag), 32'd10);
    check_eq("bp_head_a_dat", bus.cdb_data,     32'd2);
    // Full, grant and in_valid together: pop only.
    bus.cdb_grant = 1'b1;
    step();
    check_eq("full_pop_stall", 32'(bus.stall),   32'd0);
    check_eq("full_pop_tag",   32'(bus.cdb_tag), 32'd11);
    check_eq("full_pop_data",  bus.cdb_data,     32'd4);
    step();
    bus.in_valid = 1'b0;
    check_eq("drain_c_req",  32'(bus.cdb_req), 32'd1);
    check_eq("drain_c_tag",  32'(bus.cdb_tag), 32'd12);
    check_eq("drain_c_data", bus.cdb_data,     32'd6);
    step();
    check_eq("drain_empty", 32'(bus.cdb_req), 32'd0);

    // Flush during MUL_BUSY with one buffered entry and a new issue.
    bus.cdb_grant = 1'b0;
    drive_issue(ALU_ADD, 6'd20, 32'd10, 32'd20);
    step();
    drive_issue(ALU_MUL, 6'd21, 32'd3, 32'd4);
    step();
    check_eq("fl_pre_stall", 32'(bus.stall),   32'd1);
    check_eq("fl_pre_req",   32'(bus.cdb_req), 32'd1);
    drive_issue(ALU_ADD, 6'd22, 32'd1, 32'd2);
    flush         = 1'b1;
    bus.cdb_grant = 1'b1;
    step();
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.cdb_grant = 1'b0;
    check_eq("fl_req",   32'(bus.cdb_req), 32'd0);
    check_eq("fl_stall", 32'(bus.stall),   32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("fl_no_result", 32'(bus.cdb_req), 32'd0);
    end

    // Reset with a buffered entry and a multiply in flight, flush also high.
    drive_issue(ALU_ADD, 6'd30, 32'd1, 32'd1);
    step();
    drive_issue(ALU_MUL, 6'd31, 32'd5, 32'd6);
    step();
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    flush        = 1'b1;
    step();
    rst_n = 1'b1;
    flush = 1'b0;
    check_eq("mrst_req",   32'(bus.cdb_req), 32'd0);
    check_eq("mrst_stall", 32'(bus.stall),   32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("mrst_no_result", 32'(bus.cdb_req), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
